// File: rtl/ft245_async_fifo_if.sv
// Bridge between an FT245-style asynchronous byte FIFO and the valid/ack
// simple interface. All FT245 strobe timing is generated from clk, with
// pulse widths derived from CLOCK_PERIOD_NS. The pad tristate cell lives
// outside; this block supplies bus data, output enable, and takes bus input.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  IDLE      | strobes inactive, decide next transfer from synced flags
//  RD_PULSE  | RD# low, byte sampled on the last cycle
//  WR_SETUP  | data and OE driven, WR still low
//  WR_PULSE  | WR high, FT245 latches on its falling edge
//  WR_HOLD   | WR low again, data and OE held one more cycle
//  RECOVER   | all strobes inactive so the FT245 can precharge/update flags
module ft245_async_fifo_if #(
    parameter int  FT245_WIDTH     = 8,
    parameter real CLOCK_PERIOD_NS = 10.0,
    parameter int  T_PULSE_NS      = 50,
    parameter int  T_SETUP_NS      = 20,
    parameter int  T_RECOVER_NS    = 80
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FT245_WIDTH-1:0] rx_data_245,
    input  logic                   rxf_245,
    output logic                   rx_245,
    output logic [FT245_WIDTH-1:0] tx_data_245,
    input  logic                   txe_245,
    output logic                   wr_245,
    output logic                   tx_oe_245,
    output logic [FT245_WIDTH-1:0] rx_data_si,
    output logic                   rx_rdy_si,
    input  logic                   rx_ack_si,
    input  logic [FT245_WIDTH-1:0] tx_data_si,
    input  logic                   tx_rdy_si,
    output logic                   tx_ack_si
);

    // Ceiling of t_ns / CLOCK_PERIOD_NS, never less than one cycle.
    function automatic int cycles_for(input int t_ns);
        real ratio;
        int  n;
        ratio = real'(t_ns) / CLOCK_PERIOD_NS;
        n     = int'(ratio);
        if (real'(n) < ratio) n = n + 1;
        return (n < 1) ? 1 : n;
    endfunction

    localparam int N_PULSE   = cycles_for(T_PULSE_NS);
    localparam int N_SETUP   = cycles_for(T_SETUP_NS);
    localparam int N_RECOVER = cycles_for(T_RECOVER_NS);
    localparam int N_MAX_A   = (N_PULSE > N_SETUP) ? N_PULSE : N_SETUP;
    localparam int N_MAX     = (N_MAX_A > N_RECOVER) ? N_MAX_A : N_RECOVER;
    localparam int CNT_W     = $clog2(N_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_PULSE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        RECOVER
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             rxf_s1, rxf_s2;
    logic             txe_s1, txe_s2;
    logic             last_tx;
    logic             start_rx, start_tx, rd_last, rd_done;
    logic             rx_ok, tx_ok;

    // Two-stage synchronizers for the asynchronous FT245 flags, preset inactive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxf_s1 <= 1'b1;
            rxf_s2 <= 1'b1;
            txe_s1 <= 1'b1;
            txe_s2 <= 1'b1;
        end else begin
            rxf_s1 <= rxf_245;
            rxf_s2 <= rxf_s1;
            txe_s1 <= txe_245;
            txe_s2 <= txe_s1;
        end
    end

    assign rx_ok = !rxf_s2 && !rx_rdy_si;
    assign tx_ok = !txe_s2 && tx_rdy_si;

    // State register, phase down-counter and last-served direction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            last_tx <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (start_rx) last_tx <= 1'b0;
            else if (start_tx) last_tx <= 1'b1;
        end
    end

    // Next-state logic; on contention the direction not served last wins.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        start_rx  = 1'b0;
        start_tx  = 1'b0;
        rd_last   = 1'b0;
        case (state)
            IDLE: begin
                if (rx_ok && (!tx_ok || last_tx)) begin
                    state_nxt = RD_PULSE;
                    cnt_nxt   = CNT_W'(N_PULSE - 1);
                    start_rx  = 1'b1;
                end else if (tx_ok) begin
                    state_nxt = WR_SETUP;
                    cnt_nxt   = CNT_W'(N_SETUP - 1);
                    start_tx  = 1'b1;
                end
            end
            RD_PULSE: begin
                if (cnt == '0) begin
                    state_nxt = RECOVER;
                    cnt_nxt   = CNT_W'(N_RECOVER - 1);
                    rd_last   = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            WR_SETUP: begin
                if (cnt == '0) begin
                    state_nxt = WR_PULSE;
                    cnt_nxt   = CNT_W'(N_PULSE - 1);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            WR_PULSE: begin
                if (cnt == '0) begin
                    state_nxt = WR_HOLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            WR_HOLD: begin
                state_nxt = RECOVER;
                cnt_nxt   = CNT_W'(N_RECOVER - 1);
            end
            RECOVER: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // FT245-side outputs registered from the next state so strobes are glitch-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_245      <= 1'b1;
            wr_245      <= 1'b0;
            tx_oe_245   <= 1'b0;
            tx_ack_si   <= 1'b0;
            tx_data_245 <= '0;
        end else begin
            rx_245    <= (state_nxt != RD_PULSE);
            wr_245    <= (state_nxt == WR_PULSE);
            tx_oe_245 <= (state_nxt == WR_SETUP) || (state_nxt == WR_PULSE) ||
                         (state_nxt == WR_HOLD);
            tx_ack_si <= start_tx;
            if (start_tx) tx_data_245 <= tx_data_si;
        end
    end

    // Receive holding register: byte captured as RD# rises, valid flag a cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data_si <= '0;
            rx_rdy_si  <= 1'b0;
            rd_done    <= 1'b0;
        end else begin
            rd_done <= rd_last;
            if (rd_last) rx_data_si <= rx_data_245;
            if (rd_done) rx_rdy_si <= 1'b1;
            else if (rx_ack_si && rx_rdy_si) rx_rdy_si <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ft245_async_fifo_if.sv
// Bench for ft245_async_fifo_if: reset table, directed timing sequences and
// a randomized run against a queue-based model of the FT245 and si endpoints.
module tb_ft245_async_fifo_if;

    localparam int W         = 8;
    localparam int N_PULSE   = 5;
    localparam int N_SETUP   = 2;
    localparam int N_RECOVER = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] rx_data_245;
    logic         rxf_245;
    logic         rx_245;
    logic [W-1:0] tx_data_245;
    logic         txe_245;
    logic         wr_245;
    logic         tx_oe_245;
    logic [W-1:0] rx_data_si;
    logic         rx_rdy_si;
    logic         rx_ack_si;
    logic [W-1:0] tx_data_si;
    logic         tx_rdy_si;
    logic         tx_ack_si;

    ft245_async_fifo_if dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data_245 (rx_data_245),
        .rxf_245     (rxf_245),
        .rx_245      (rx_245),
        .tx_data_245 (tx_data_245),
        .txe_245     (txe_245),
        .wr_245      (wr_245),
        .tx_oe_245   (tx_oe_245),
        .rx_data_si  (rx_data_si),
        .rx_rdy_si   (rx_rdy_si),
        .rx_ack_si   (rx_ack_si),
        .tx_data_si  (tx_data_si),
        .tx_rdy_si   (tx_rdy_si),
        .tx_ack_si   (tx_ack_si)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Protocol monitor: strobe widths, setup/hold, OE/RD exclusion, FT245 write latch.
    int        rd_w, wr_w, setup_cnt, hold_cnt, wr_phase;
    int        rd_fall_cnt = 0, oe_rise_cnt = 0, wr_fall_cnt = 0, overlap_cnt = 0;
    logic      prev_rx = 1'b1, prev_wr = 1'b0, prev_oe = 1'b0;
    int        txn_q[$];
    logic [7:0] ft_tx_got[$];

    always @(negedge clk) begin
        if (!rst) begin
            rd_w = 0; wr_w = 0; setup_cnt = 0; hold_cnt = 0; wr_phase = 0;
            prev_rx = 1'b1; prev_wr = 1'b0; prev_oe = 1'b0;
        end else begin
            if (!prev_oe && tx_oe_245) begin
                oe_rise_cnt++;
                txn_q.push_back(1);
                setup_cnt = 0; hold_cnt = 0; wr_phase = 0;
            end
            if (prev_rx && !rx_245) begin
                rd_fall_cnt++;
                txn_q.push_back(0);
            end
            if (tx_oe_245 && !rx_245) overlap_cnt++;
            if (!rx_245) rd_w++;
            else if (!prev_rx) begin
                check("rd_pulse_width", rd_w, N_PULSE);
                rd_w = 0;
            end
            if (wr_245) begin
                if (!prev_wr) begin
                    check("wr_setup_cycles", setup_cnt, N_SETUP);
                    wr_phase = 1;
                end
                wr_w++;
            end else if (prev_wr) begin
                check("wr_pulse_width", wr_w, N_PULSE);
                check("oe_at_wr_fall", tx_oe_245, 1);
                ft_tx_got.push_back(tx_data_245);
                wr_fall_cnt++;
                wr_w = 0;
                wr_phase = 2;
            end
            if (tx_oe_245 && !wr_245) begin
                if (wr_phase == 0) setup_cnt++;
                else if (wr_phase == 2) hold_cnt++;
            end
            if (prev_oe && !tx_oe_245) check("wr_hold_cycles", hold_cnt, 1);
            prev_rx = rx_245; prev_wr = wr_245; prev_oe = tx_oe_245;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic idle_inputs();
        rxf_245 = 1'b1; txe_245 = 1'b1; rx_ack_si = 1'b0;
        tx_rdy_si = 1'b0; tx_data_si = '0; rx_data_245 = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        repeat (2) step();
        rst = 1'b1;
        step();
    endtask

    // Reference model state for the randomized run.
    logic [7:0] ft_rx_q[$];
    logic [7:0] rx_ref[$];
    logic [7:0] tx_ref[$];
    logic       prev_rx_l;
    bit         ft_busy;
    int         ft_delay, txe_hold, seen_wr_falls;

    task automatic rand_cycle(input bit allow_new);
        logic [7:0] b;
        step();
        // FT245 read side: byte leaves the FIFO when RD# rises, flag blanked around it.
        if (prev_rx_l && !rx_245) ft_busy = 1'b1;
        if (!prev_rx_l && rx_245) begin
            if (ft_rx_q.size() > 0) b = ft_rx_q.pop_front();
            ft_busy  = 1'b0;
            ft_delay = 3;
        end
        prev_rx_l = rx_245;
        if (ft_delay > 0) ft_delay--;
        if (allow_new && ft_rx_q.size() < 2 && $urandom_range(0, 5) == 0) begin
            b = 8'($urandom);
            ft_rx_q.push_back(b);
            rx_ref.push_back(b);
        end
        rxf_245 = !(ft_rx_q.size() > 0 && !ft_busy && ft_delay == 0);
        rx_data_245 = (!rx_245 && ft_rx_q.size() > 0) ? ft_rx_q[0] : 8'($urandom);
        // Consumer: bytes must arrive in FT245 order; stray acks while empty are ignored.
        if (rx_rdy_si && !rx_ack_si && $urandom_range(0, 3) == 0) begin
            check("rx_ref_nonempty", rx_ref.size() != 0, 1);
            if (rx_ref.size() != 0) check("rx_byte", rx_data_si, rx_ref.pop_front());
            rx_ack_si = 1'b1;
        end else if (rx_rdy_si) begin
            rx_ack_si = 1'b0;
        end else begin
            rx_ack_si = 1'($urandom_range(0, 1));
        end
        // Producer: a byte counts as sent once tx_ack_si is seen.
        if (tx_ack_si) begin
            tx_ref.push_back(tx_data_si);
            tx_rdy_si = 1'b0;
        end
        if (allow_new && !tx_rdy_si && $urandom_range(0, 3) == 0) begin
            tx_rdy_si  = 1'b1;
            tx_data_si = 8'($urandom);
        end
        // FT245 write side: bytes latched on WR fall must match producer order.
        while (ft_tx_got.size() > 0) begin
            b = ft_tx_got.pop_front();
            check("tx_ref_nonempty", tx_ref.size() != 0, 1);
            if (tx_ref.size() != 0) check("tx_byte", b, tx_ref.pop_front());
        end
        if (wr_fall_cnt != seen_wr_falls) begin
            seen_wr_falls = wr_fall_cnt;
            txe_hold = $urandom_range(2, 12);
        end else if (txe_hold == 0 && $urandom_range(0, 40) == 0) begin
            txe_hold = $urandom_range(1, 20);
        end
        if (txe_hold > 0) txe_hold--;
        txe_245 = (txe_hold > 0);
    endtask

    typedef struct {
        logic       rxf, txe, tx_rdy, rx_ack;
        logic [7:0] txd, rxd;
        logic       e_rx, e_wr, e_oe, e_rdy, e_ack;
        logic [7:0] e_rxdata, e_txdata;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int lat, w, cnt, f0, a0;

        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h81, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};

        // Reset table: outputs pinned to reset values whatever the inputs do.
        rst = 1'b0;
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            rxf_245 = vecs[i].rxf; txe_245 = vecs[i].txe;
            tx_rdy_si = vecs[i].tx_rdy; rx_ack_si = vecs[i].rx_ack;
            tx_data_si = vecs[i].txd; rx_data_245 = vecs[i].rxd;
            repeat (3) step();
            check("rst_rx_245", rx_245, vecs[i].e_rx);
            check("rst_wr_245", wr_245, vecs[i].e_wr);
            check("rst_tx_oe", tx_oe_245, vecs[i].e_oe);
            check("rst_rx_rdy", rx_rdy_si, vecs[i].e_rdy);
            check("rst_tx_ack", tx_ack_si, vecs[i].e_ack);
            check("rst_rx_data_si", rx_data_si, vecs[i].e_rxdata);
            check("rst_tx_data_245", tx_data_245, vecs[i].e_txdata);
        end

        // Single read, then backpressure with the flag held low.
        do_reset();
        rx_data_245 = 8'hA5;
        rxf_245 = 1'b0;
        lat = 0;
        while (rx_245 && lat < 20) begin step(); lat++; end
        check("rd_latency", lat, 3);
        w = 0;
        while (!rx_245 && w < 20) begin step(); w++; end
        check("rd_low_cycles", w, N_PULSE);
        check("rdy_not_yet", rx_rdy_si, 0);
        step();
        check("rdy_after_rd", rx_rdy_si, 1);
        check("rx_data_a5", rx_data_si, 8'hA5);
        rx_data_245 = 8'h5A;
        f0 = rd_fall_cnt;
        repeat (40) step();
        check("backpressure_no_rd", rd_fall_cnt - f0, 0);
        check("rdy_held", rx_rdy_si, 1);
        check("rx_data_stable", rx_data_si, 8'hA5);
        rx_ack_si = 1'b1;
        step();
        rx_ack_si = 1'b0;
        check("rdy_cleared", rx_rdy_si, 0);
        cnt = 0;
        while (rd_fall_cnt == f0 && cnt < 30) begin step(); cnt++; end
        check("second_rd_pulse", rd_fall_cnt - f0, 1);
        cnt = 0;
        while (!rx_rdy_si && cnt < 30) begin step(); cnt++; end
        check("rx_data_5a", rx_data_si, 8'h5A);
        rx_ack_si = 1'b1;
        step();
        rx_ack_si = 1'b0;
        // A third read starts; reset in the middle of it discards the byte.
        cnt = 0;
        while (rx_245 && cnt < 30) begin step(); cnt++; end
        check("third_rd_started", rx_245, 0);
        step();
        #2 rst = 1'b0;
        #1;
        check("async_rst_rx_245", rx_245, 1);
        rxf_245 = 1'b1;
        repeat (2) step();
        rst = 1'b1;
        repeat (12) step();
        check("rst_discards_byte", rx_rdy_si, 0);

        // Single write.
        do_reset();
        txe_245 = 1'b0; tx_rdy_si = 1'b1; tx_data_si = 8'h3C;
        lat = 0;
        while (!tx_ack_si && lat < 20) begin step(); lat++; end
        check("wr_ack_latency", lat, 3);
        check("wr_oe_with_ack", tx_oe_245, 1);
        check("wr_tx_data_3c", tx_data_245, 8'h3C);
        tx_rdy_si = 1'b0; tx_data_si = 8'hEE;
        step();
        check("tx_ack_one_cycle", tx_ack_si, 0);
        w = 1;
        while (!wr_245 && w < 20) begin step(); w++; end
        check("oe_to_wr", w, N_SETUP);
        w = 0;
        while (wr_245 && w < 20) begin step(); w++; end
        check("wr_high_cycles", w, N_PULSE);
        check("oe_hold_after_wr", tx_oe_245, 1);
        check("ft_latched_3c", (ft_tx_got.size() > 0) ? ft_tx_got[0] : 8'h00, 8'h3C);
        step();
        check("oe_drop", tx_oe_245, 0);
        txe_245 = 1'b1;

        // Write blocked by TXE#.
        do_reset();
        txe_245 = 1'b1; tx_rdy_si = 1'b1; tx_data_si = 8'h81;
        a0 = oe_rise_cnt; cnt = 0;
        repeat (20) begin step(); if (tx_ack_si) cnt++; end
        check("blocked_no_ack", cnt, 0);
        check("blocked_no_wr", oe_rise_cnt - a0, 0);
        txe_245 = 1'b0;
        lat = 0;
        while (!tx_ack_si && lat < 20) begin step(); lat++; end
        check("unblocked_ack_latency", lat, 3);
        tx_rdy_si = 1'b0;
        repeat (20) step();

        // Contention: directions must alternate.
        do_reset();
        txn_q.delete();
        f0 = overlap_cnt;
        rxf_245 = 1'b0; txe_245 = 1'b0; tx_rdy_si = 1'b1; tx_data_si = 8'h11;
        cnt = 0;
        while (txn_q.size() < 4 && cnt < 300) begin
            step(); cnt++;
            rx_data_245 = 8'($urandom);
            rx_ack_si = rx_rdy_si && !rx_ack_si;
            if (tx_ack_si) tx_data_si = tx_data_si + 8'h11;
        end
        check("contention_txns", txn_q.size() >= 4, 1);
        if (txn_q.size() >= 4) begin
            check("contention_0_rx", txn_q[0], 0);
            check("contention_1_tx", txn_q[1], 1);
            check("contention_2_rx", txn_q[2], 0);
            check("contention_3_tx", txn_q[3], 1);
        end
        check("contention_no_overlap", overlap_cnt - f0, 0);

        // Randomized run against the queue model.
        do_reset();
        ft_rx_q.delete(); rx_ref.delete(); tx_ref.delete(); ft_tx_got.delete();
        prev_rx_l = 1'b1; ft_busy = 1'b0; ft_delay = 0; txe_hold = 0;
        seen_wr_falls = wr_fall_cnt;
        f0 = rd_fall_cnt; a0 = wr_fall_cnt;
        for (int i = 0; i < 5000; i++) rand_cycle(1'b1);
        for (int i = 0; i < 600; i++) rand_cycle(1'b0);
        check("rand_rx_drained", rx_ref.size(), 0);
        check("rand_ft_rx_empty", ft_rx_q.size(), 0);
        check("rand_tx_drained", tx_ref.size(), 0);
        check("rand_reads_seen", (rd_fall_cnt - f0) > 20, 1);
        check("rand_writes_seen", (wr_fall_cnt - a0) > 20, 1);
        check("no_oe_rd_overlap", overlap_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ft245_async_fifo_if.md
Name: ft245_async_fifo_if

Overview:
- Clocked bridge between an FTDI FT245-style asynchronous byte FIFO (active-low RXF#/TXE# flags, RD#/WR strobes, bidirectional data bus) and the internal valid/ack "simple interface" (si).
- Generates all FT245 strobe timing from the system clock, with pulse widths derived from CLOCK_PERIOD_NS.
- Sits directly behind the FPGA I/O tristate cells. It supplies the bus output data and output-enable and receives the bus input data; it does not drive the inout pad itself.

Parameters:
- FT245_WIDTH, 8: data bus width in bits.
- CLOCK_PERIOD_NS, 10.0: clk period in ns, used to derive cycle counts.
- T_PULSE_NS, 50: minimum active width of the RD# and WR strobes.
- T_SETUP_NS, 20: minimum time data/OE is driven before WR is asserted.
- T_RECOVER_NS, 80: minimum strobe-inactive time between transactions. Covers the 50 ns precharge plus the flag update delay.
- Derived cycle counts: N_x = ceil(T_x_NS / CLOCK_PERIOD_NS), minimum 1. At 10 ns: N_PULSE=5, N_SETUP=2, N_RECOVER=8.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- rx_data_245  in  W  data bus input, from the pad buffer.
- rxf_245  in  1  RXF#; low means the FT245 holds an unread byte. Asynchronous.
- rx_245  out  1  RD#, active low.
- tx_data_245  out  W  data bus output, to the pad buffer.
- txe_245  in  1  TXE#; low means the FT245 can accept a byte. Asynchronous.
- wr_245  out  1  WR, active high; the FT245 latches data on its falling edge.
- tx_oe_245  out  1  pad output enable; high drives the bus.
- rx_data_si  out  W  received byte.
- rx_rdy_si  out  1  high while rx_data_si holds an unconsumed byte.
- rx_ack_si  in  1  consumer acknowledge.
- tx_data_si  in  W  byte to send.
- tx_rdy_si  in  1  producer has a byte on tx_data_si.
- tx_ack_si  out  1  one-cycle pulse: tx_data_si has been taken.

Behaviour:
- Reset values while rst is low, asynchronously:
  - rx_245=1, wr_245=0, tx_oe_245=0, tx_data_245=0.
  - rx_data_si=0, rx_rdy_si=0, tx_ack_si=0.
  - Synchronizers preset to 1 (flags inactive); FSM in IDLE.
- rxf_245 and txe_245 each pass through a 2-FF synchronizer. All decisions use the synchronized values.
- FSM states: IDLE, RD_PULSE, WR_SETUP, WR_PULSE, WR_HOLD, RECOVER.
- IDLE decision:
  - rx_ok = sync rxf low AND rx_rdy_si low.
  - tx_ok = sync txe low AND tx_rdy_si high.
  - If both are set, serve the direction not served by the previous transaction (RX first after reset). Otherwise serve whichever is set.
- Read:
  - RD_PULSE drives rx_245 low for N_PULSE cycles.
  - On the last cycle, rx_data_245 is registered into rx_data_si and rx_245 returns high.
  - rx_rdy_si is set in the next cycle, then go to RECOVER.
- RX handshake:
  - rx_rdy_si stays high, with rx_data_si stable, until a cycle where rx_ack_si=1 and rx_rdy_si=1. It clears on the following edge.
  - rx_ack_si while rx_rdy_si=0 is ignored.
  - No new read starts while rx_rdy_si=1; this is the backpressure toward the FT245.
- Write:
  - On entry from IDLE, tx_data_si is captured into tx_data_245 and tx_ack_si pulses for exactly one cycle.
  - WR_SETUP: tx_oe_245=1, wr_245=0 for N_SETUP cycles.
  - WR_PULSE: wr_245=1 for N_PULSE cycles.
  - WR_HOLD: wr_245=0, data and OE still held for 1 cycle.
  - Then tx_oe_245=0 and go to RECOVER.
- tx_oe_245 is never high while rx_245 is low.
- RECOVER: all strobes inactive, OE low, for N_RECOVER cycles, then IDLE.
- Every flag change from the FT245 is seen through the synchronizers before the next decision.
- The flags are checked only in IDLE. A flag deasserting mid-transaction does not abort that transaction.
- Reset mid-transaction: immediate return to the reset values. A partially read byte is discarded.
- The producer must hold tx_data_si stable while tx_rdy_si=1 until tx_ack_si.

Test Plan:
- Reset: rst=0 with arbitrary inputs -> rx_245=1, wr_245=0, tx_oe_245=0, rx_rdy_si=0, tx_ack_si=0.
- Single read:
  - Stimulus: rxf_245 falls, bus=0xA5.
  - Required: rx_245 goes low 3 cycles later (2 sync cycles + IDLE decision) and stays low 5 cycles.
  - Required: rx_rdy_si=1 with rx_data_si=0xA5 one cycle after rx_245 rises; it holds until rx_ack_si, then clears next edge.
- Backpressure: rxf_245 held low, no rx_ack_si -> exactly one RD# pulse. After an ack and the 8-cycle recover, a second pulse occurs.
- Single write:
  - Stimulus: txe_245 low, tx_rdy_si=1, tx_data_si=0x3C.
  - Required: tx_ack_si pulses for 1 cycle; tx_oe_245=1 and tx_data_245=0x3C.
  - Required: wr_245 high 5 cycles, starting 2 cycles after OE rises; OE drops 1 cycle after wr falls.
- Write blocked: txe_245=1, tx_rdy_si=1 -> no tx_ack_si and no WR; a write starts 3 cycles after txe_245 falls.
- Contention: rxf_245=0, txe_245=0, tx_rdy_si=1, ack every byte -> transactions alternate RX, TX, RX, TX, and OE never overlaps RD# low.
